// File: rtl/mips_mem_arbiter.sv
// Shared single-port memory arbiter for the MIPS fetch and load/store ports.
// Define ARB_TIMEOUT_EN to build the mem_ack timeout counter and the sticky err flag.
module mips_mem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [3:0]    STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [DW-1:0] FILL_WORD  = DW'(32'hDEADBEEF);

  if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15 || TIMEOUT < 1) begin : g_param_check
    $error("mips_mem_arbiter: MAX_D_STREAK must be 1..15 and TIMEOUT >= 1");
  end

  logic [1:0] state;
  logic [3:0] streak;
  logic       d_win;
  logic       timeout_hit;

  // Data wins unless fetch is waiting and data has used up its streak.
  assign d_win = d_req && !(i_req && (streak == STREAK_MAX));

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt;
  logic          err_q;
  logic          busy;

  assign busy        = (state == BUSY_I) || (state == BUSY_D);
  assign timeout_hit = busy && !mem_ack && (tcnt == TW'(TIMEOUT));
  assign err         = err_q;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (!busy) begin
        tcnt <= '0;
      end else if (!mem_ack && !timeout_hit) begin
        tcnt <= tcnt + TW'(1);
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (d_win) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state     <= BUSY_D;
            if (!i_req) begin
              streak <= '0;
            end else if (streak != STREAK_MAX) begin
              streak <= streak + 4'd1;
            end
          end else if (i_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            streak    <= '0;
            state     <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          // A timeout completes the transaction like an ack, returning the fill word.
          if (mem_ack || timeout_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= RESP;
            if (state == BUSY_I) begin
              i_ack   <= 1'b1;
              i_rdata <= mem_ack ? mem_rdata : FILL_WORD;
            end else begin
              d_ack <= 1'b1;
              if (!mem_we) begin
                d_rdata <= mem_ack ? mem_rdata : FILL_WORD;
              end
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
Arbitrates one shared single-port memory between the pipelined MIPS instruction-fetch port and its data (load/store) port.
- Data requests win by default, because the older instruction is in MEM.
- A streak limit stops fetch from starving.
- Each transaction is fully serialized: grant, wait for the memory ack, return a one-cycle ack to the requester.
- Sits between the core's IF/MEM stages and the unified memory / GPIO-mapped bus.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_D_STREAK, 4, consecutive data grants allowed while i_req is pending before fetch is forced; legal range 1..15
TIMEOUT, 64, cycles to wait for mem_ack (used only with ARB_TIMEOUT_EN)

Ports:
Clk  in  1  clock, all logic on rising edge
Rst  in  1  synchronous, active-low reset
i_req  in  1  fetch request, held until i_ack
i_addr  in  AW  fetch address, stable while i_req
i_ack  out  1  one-cycle fetch completion pulse
i_rdata  out  DW  fetched word, registered
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  DW  load data, registered
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  memory completion; may assert in the first cycle mem_req is high
err  out  1  sticky timeout flag (only with ARB_TIMEOUT_EN; tied 0 otherwise)

Behaviour:
- Reset (Rst=0 at a rising edge):
  - All outputs go to 0; i_rdata and d_rdata go to 0.
  - State goes to IDLE; streak counter goes to 0.
  - Any in-flight transaction is abandoned with no ack.
  - Reset overrides every other event.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - d_req only -> BUSY_D.
  - i_req only -> BUSY_I.
  - Both -> BUSY_D, unless streak == MAX_D_STREAK, in which case -> BUSY_I.
  - Neither -> stay in IDLE.
- Grant capture: on the transition into BUSY_x, register the requester's address (plus we/wdata for data) onto the mem_* outputs and set mem_req=1. For a fetch grant, mem_we=0 and mem_wdata=0.
- BUSY_x:
  - Hold mem_* stable.
  - On mem_ack=1: mem_req=0, mem_we=0; capture mem_rdata into x_rdata, but only for a fetch or a load; a store leaves d_rdata unchanged. Then -> RESP.
- RESP:
  - The granted port's x_ack is 1 for exactly this cycle; then -> IDLE.
  - The arbiter never samples requests in RESP, so a requester's stale req in its ack cycle is never regranted.
- Latency: request seen in IDLE at cycle 0 -> mem_req high from cycle 1 -> mem_ack at cycle k>=1 -> x_ack at cycle k+1 -> IDLE at k+2.
  - Minimum is 3 cycles per transaction; back-to-back throughput is one transaction per 3 cycles with a 1-cycle memory.
- Streak counter (4 bits):
  - Increments on a data grant made while i_req=1.
  - Clears to 0 on any fetch grant.
  - Clears on a data grant made with i_req=0.
  - Saturates at MAX_D_STREAK.
- The mem_ack input is ignored outside BUSY states.
- Requester protocol violations (req dropped before ack) do not abort the transaction; the ack pulse is still issued.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A counter clears on BUSY entry and increments each BUSY cycle without mem_ack.
  - When it reaches TIMEOUT, the arbiter drops mem_req, loads x_rdata with 32'hDEADBEEF (for a load or fetch), sets err=1, and goes to RESP, so the ack is still delivered.
  - err is sticky until reset.
- Undefined: no counter is built; BUSY waits indefinitely; err is constant 0.

Test Plan:
- Reset: hold Rst=0 for 2 edges with i_req=d_req=1 -> all outputs 0, no mem_req; the first grant occurs at the cycle after Rst=1.
- Single fetch: i_addr=0x40, memory acks 2 cycles after mem_req with mem_rdata=0x20100007 -> mem_addr=0x40 and mem_we=0 from cycle 1; i_ack pulses once at cycle 3; i_rdata=0x20100007.
- Simultaneous: i_req and d_req (load, addr 0x800) both raised at cycle 0 -> data served first; i_ack follows in the next transaction; mem_addr sequence is 0x800 then i_addr.
- Starvation: d_req and i_req held continuously, 1-cycle memory -> exactly 4 d_acks, then 1 i_ack, then data resumes; streak is back to 0 after the fetch grant.
- Store: d_we=1, d_addr=0x804, d_wdata=0x78 -> mem_we=1, mem_wdata=0x78 until mem_ack; d_ack pulses once; d_rdata is unchanged from its previous value.
- Reset mid-BUSY, plus timeout (ARB_TIMEOUT_EN, TIMEOUT=8, memory never acks):
  - Reset -> mem_req=0 next edge, no ack.
  - Timeout case -> i_ack is issued 9 cycles after the grant with i_rdata=0xDEADBEEF and err=1.
